// File: rtl/muldiv_unit.sv
// Iterative RV M-extension multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, sign fix-up in a final cycle.
//
// state | meaning
// IDLE  | waiting for start; operands captured on accept
// CALC  | one radix-2 step per cycle, XLEN cycles, counted down
// FIX   | sign correction, result registered on exit
// DONE  | done pulse for one cycle, result valid
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]        op;
  logic [XLEN-1:0]   bmag;
  logic [2*XLEN-1:0] acc;
  logic              neg_q, neg_r;
  logic [CW-1:0]     cnt;

  logic            a_sgn_in, b_sgn_in, a_neg_in, b_neg_in;
  logic            div0_in, ovf_in, fast_in, accept;
  logic [XLEN-1:0] amag_in, bmag_in, fast_res;

  assign a_sgn_in = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
  assign b_sgn_in = a_sgn_in && (funct3 != 3'b010);
  assign a_neg_in = a_sgn_in & srca[XLEN-1];
  assign b_neg_in = b_sgn_in & srcb[XLEN-1];
  assign amag_in  = a_neg_in ? -srca : srca;
  assign bmag_in  = b_neg_in ? -srcb : srcb;
  assign div0_in  = funct3[2] && (srcb == '0);
  assign ovf_in   = funct3[2] && !funct3[0] && (srca == MIN_NEG) && (srcb == '1);
  assign fast_in  = div0_in | ovf_in;
  assign accept   = (state == IDLE) && start && !flush;

  always_comb begin
    fast_res = srca;
    if (div0_in) fast_res = funct3[1] ? srca : '1;
    else         fast_res = funct3[1] ? '0 : srca;
  end

  // Multiply: conditional add into the upper half, then shift right.
  logic [XLEN:0]     msum;
  logic [2*XLEN-1:0] mul_nxt;
  assign msum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, bmag & {XLEN{acc[0]}}};
  assign mul_nxt = {msum, acc[XLEN-1:1]};

  // Divide: acc holds {remainder, quotient}; shift in a dividend bit, try subtract.
  logic [XLEN:0]     dsh, ddiff;
  logic              dge;
  logic [2*XLEN-1:0] div_nxt;
  assign dsh     = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign ddiff   = dsh - {1'b0, bmag};
  assign dge     = !ddiff[XLEN];
  assign div_nxt = {(dge ? ddiff[XLEN-1:0] : dsh[XLEN-1:0]), acc[XLEN-2:0], dge};

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;
  assign prod_fix = neg_q ? -acc : acc;
  assign quo_fix  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem_fix  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = prod_fix[2*XLEN-1:XLEN];
    case (op)
      3'b000:         fix_res = prod_fix[XLEN-1:0];
      3'b100, 3'b101: fix_res = quo_fix;
      3'b110, 3'b111: fix_res = rem_fix;
      default:        fix_res = prod_fix[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = fast_in ? DONE : CALC;
        CALC:    if (cnt == CW'(1)) state_nxt = FIX;
        FIX:     state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op     <= '0;
      bmag   <= '0;
      acc    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      cnt    <= '0;
      result <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (accept) begin
      op    <= funct3;
      bmag  <= bmag_in;
      acc   <= {{XLEN{1'b0}}, amag_in};
      neg_q <= a_neg_in ^ b_neg_in;
      neg_r <= a_neg_in;
      if (fast_in) begin
        cnt    <= '0;
        result <= fast_res;
      end else begin
        cnt <= CW'(XLEN);
      end
    end else if (state == CALC) begin
      acc <= op[2] ? div_nxt : mul_nxt;
      cnt <= cnt - CW'(1);
    end else if (state == FIX) begin
      result <= fix_res;
    end
  end

  assign busy = (state == CALC) || (state == FIX);
  assign done = (state == DONE);

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL provide parameter XLEN, default 32, meaning the operand and result width in bits (supported: 8, 16, 32, 64).
REQ-002 SHALL provide port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL provide port start, input, 1 bit: request a new operation.
REQ-005 SHALL provide port flush, input, 1 bit: abort any operation in progress.
REQ-006 SHALL provide port funct3, input, 3 bits: RV M-extension op (000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu).
REQ-007 SHALL provide ports srca and srcb, input, XLEN bits each: operand a (rs1) and operand b (rs2).
REQ-008 SHALL provide port busy, output, 1 bit: an operation is in progress.
REQ-009 SHALL provide port done, output, 1 bit: single-cycle pulse marking result valid.
REQ-010 SHALL provide port result, output, XLEN bits: registered result.

Function
REQ-011 SHALL implement states IDLE, CALC, FIX, DONE.
REQ-012 SHALL accept start only in IDLE, capturing funct3, srca and srcb on that edge; start in CALC/FIX/DONE is ignored.
REQ-013 SHALL, on accept of a normal operation, enter CALC with iteration counter = XLEN.
REQ-014 SHALL perform one radix-2 step per CALC cycle: shift-add multiply on magnitudes, restoring divide on magnitudes.
REQ-015 SHALL leave CALC for FIX after exactly XLEN CALC cycles, and go FIX -> DONE after one cycle.
REQ-016 SHALL apply sign correction in FIX and register result on the FIX->DONE edge.
REQ-017 SHALL apply signedness: mul/mulh/div/rem signed x signed; mulhsu signed srca x unsigned srcb; mulhu/divu/remu unsigned.
REQ-018 SHALL form the 2*XLEN-bit product internally; mul returns the low XLEN bits, mulh* the high XLEN bits.
REQ-019 SHALL give the remainder the sign of the dividend and round the quotient toward zero.
REQ-020 SHALL take a fast path for divide by zero (srcb=0): quotient all ones, remainder = srca; IDLE -> DONE directly.
REQ-021 SHALL take a fast path for signed overflow (div/rem, srca = 1 followed by XLEN-1 zeros, srcb = all ones): quotient = srca, remainder = 0; IDLE -> DONE directly.
REQ-022 SHALL meet latency, counting the accept cycle as cycle 0:
  - normal op: done high in cycle XLEN+2;
  - fast path: done high in cycle 1.
REQ-023 SHALL assert done only in DONE, for exactly one cycle; DONE -> IDLE unconditionally.
REQ-024 SHALL assert busy in CALC and FIX and deassert it in IDLE and DONE.
REQ-025 SHALL hold result stable from DONE until the next operation's DONE; result is not updated by flush.
REQ-026 SHALL, on flush high in any state, return to IDLE on the next edge with done=0 and no result update; flush wins over a simultaneous start.
REQ-027 SHALL ignore operand changes after accept; captured copies are used.

Reset
REQ-028 SHALL, with reset_n low, force IDLE, busy=0, done=0, result=0 and counter=0 immediately, independent of clk.
REQ-029 SHALL abandon any operation on reset mid-operation, with no done pulse after reset_n rises.
REQ-030 SHALL ignore start on any edge where reset_n is low; first accept is possible on the first edge with reset_n high.

Verification (XLEN=32)
REQ-031 SHALL cover mul, 7 x 0xFFFFFFFD -> result 0xFFFFFFEB; done in cycle 34 only; busy high cycles 1-33.
REQ-032 SHALL cover mulh, 0x80000000 x 0x80000000 -> 0x40000000; mulhu, 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-033 SHALL cover div, 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; rem of the same operands -> 0xFFFFFFFF; remu, 7 / 2 -> 1.
REQ-034 SHALL cover the fast paths:
  - divu 5 / 0 -> 0xFFFFFFFF, done in cycle 1;
  - rem 5 / 0 -> 5;
  - div 0x80000000 / 0xFFFFFFFF -> 0x80000000, done in cycle 1.
REQ-035 SHALL cover flush and reset mid-operation:
  - flush in cycle 10 of a div -> IDLE next edge, no done, result unchanged;
  - reset_n low in cycle 5 -> all outputs 0 asynchronously.
REQ-036 SHALL cover start asserted while busy (ignored) and start held high in DONE (not accepted until IDLE), checking one done per accepted op.
